minilab0: RTL and testbench

MINILAB0 -- requirements
Module: minilab0

---
 rtl/minilab0_pkg.sv | 41 ++++
 rtl/minilab0_fifo.sv | 63 ++++++
 rtl/minilab0.sv | 119 +++++++++++
 tb/tb_minilab0.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/minilab0_pkg.sv
// Shared constants, FSM state type and seven-segment lookup for minilab0.
// Imported by the top level; the FIFO sub-module is self-contained.
package minilab0_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int ACC_WIDTH  = 24;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/minilab0_fifo.sv
// Synchronous FIFO with registered read data and full/empty flags.
// Ports: clk, rst (async high), wr_en/din, rd_en/dout, full, empty.
module fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Writes while full and reads while empty are dropped
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= nxt(wr_ptr);
            if (do_rd) begin
                rd_ptr <= nxt(rd_ptr);
                dout   <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/minilab0.sv
// Fills two FIFOs, multiply-accumulates their contents, shows result on HEX.
// Ports: CLOCK_50, KEY[0] reset (low), SW[0] display enable, HEX0..5, LEDR.
module minilab0 #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    import minilab0_pkg::*;

    localparam int IW    = $clog2(DEPTH + 1);
    localparam int PRODW = 2 * DATA_WIDTH;

    logic                  clk;
    logic                  rst;
    state_t                state;
    logic [IW-1:0]         fill_idx;
    logic                  valid;
    logic [ACC_WIDTH-1:0]  acc;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_a;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  full_a;
    logic                  full_b;
    logic                  empty_a;
    logic                  empty_b;
    logic [PRODW-1:0]      prod;
    logic                  show;
    logic                  unused_ok;

    assign clk = CLOCK_50;
    assign rst = ~KEY[0];

    assign unused_ok = ^{KEY[3:1], SW[9:1], full_a, full_b};

    assign wr_en = (state == FILL);
    assign din_a = DATA_WIDTH'(fill_idx) + DATA_WIDTH'(1);
    assign din_b = DATA_WIDTH'(fill_idx) + DATA_WIDTH'(2);
    assign rd_en = (state == EXEC) && !empty_a && !empty_b;

    fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (din_a),
        .dout  (dout_a),
        .full  (full_a),
        .empty (empty_a)
    );

    fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (din_b),
        .dout  (dout_b),
        .full  (full_b),
        .empty (empty_b)
    );

    assign prod = PRODW'(dout_a) * PRODW'(dout_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            fill_idx <= '0;
            valid    <= 1'b0;
            acc      <= '0;
        end else begin
            // Read data lands one cycle after the pop
            valid <= rd_en;
            if (valid)
                acc <= acc + ACC_WIDTH'(prod);
            case (state)
                FILL: begin
                    if (fill_idx == IW'(DEPTH - 1)) begin
                        fill_idx <= '0;
                        state    <= EXEC;
                    end else begin
                        fill_idx <= fill_idx + 1'b1;
                    end
                end
                EXEC: begin
                    // Wait for the last popped pair to be accumulated
                    if (empty_a && empty_b && !valid)
                        state <= DONE;
                end
                DONE:    state <= DONE;
                default: state <= FILL;
            endcase
        end
    end

    assign show = SW[0] && (state == DONE);
    assign LEDR = {8'b0, state};

    assign HEX0 = show ? seg7(acc[3:0])   : 7'h7F;
    assign HEX1 = show ? seg7(acc[7:4])   : 7'h7F;
    assign HEX2 = show ? seg7(acc[11:8])  : 7'h7F;
    assign HEX3 = show ? seg7(acc[15:12]) : 7'h7F;
    assign HEX4 = show ? seg7(acc[19:16]) : 7'h7F;
    assign HEX5 = show ? seg7(acc[23:20]) : 7'h7F;

endmodule

// File: tb/tb_minilab0.sv
// Self-checking bench for minilab0 and its fifo sub-module.
// Random reset/switch sequences checked against a cycle-count reference model.
module tb_minilab0;

    logic       clk;
    logic [3:0] key;
    logic [9:0] sw;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0] ledr;

    logic       f_rst, f_wr, f_rd, f_full, f_empty;
    logic [7:0] f_din, f_dout;

    int checks = 0;
    int errors = 0;
    int k = 0;

    localparam int N = 8;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    minilab0 dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5),
        .LEDR     (ledr)
    );

    fifo #(.DEPTH(8), .DATA_WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (f_rst),
        .wr_en (f_wr),
        .rd_en (f_rd),
        .din   (f_din),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sum of (i+1)*(i+2) over the fill sequence, mod 2^24
    function automatic int exp_acc();
        int s = 0;
        for (int i = 0; i < N; i++)
            s = (s + (i + 1) * (i + 2)) % (1 << 24);
        return s;
    endfunction

    function automatic logic [41:0] exp_hex(input int a);
        logic [41:0] h = '0;
        for (int d = 0; d < 6; d++)
            h[7*d +: 7] = SEG[(a >> (4 * d)) & 15];
        return h;
    endfunction

    // One clock: apply inputs after the edge, compare on the falling edge
    task automatic cyc(input logic key0, input logic sw0);
        logic [9:0]  el;
        logic [41:0] eh;
        int          code;
        @(posedge clk);
        if (key[0])
            k++;
        #1;
        key[0] = key0;
        sw[0]  = sw0;
        if (!key0)
            k = 0;
        @(negedge clk);
        if (!key0)
            code = 0;
        else if (k < N)
            code = 0;
        else if (k < 2 * N + 2)
            code = 1;
        else
            code = 2;
        el = 10'(code);
        eh = (code == 2 && sw0) ? exp_hex(exp_acc()) : {6{7'h7F}};
        check("ledr", ledr, el);
        check("hex", {hex5, hex4, hex3, hex2, hex1, hex0}, eh);
    endtask

    task automatic fcyc(input logic wr, input logic rd, input logic [7:0] d);
        f_wr  = wr;
        f_rd  = rd;
        f_din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] ed;
        key   = 4'b1110;
        sw    = 10'h001;
        f_rst = 1'b1;
        f_wr  = 1'b0;
        f_rd  = 1'b0;
        f_din = '0;

        repeat (2) @(posedge clk);
        #1;
        check("f_rst_empty", f_empty, 1'b1);
        check("f_rst_full", f_full, 1'b0);
        check("f_rst_dout", f_dout, 8'h00);
        f_rst = 1'b0;

        for (int n = 1; n <= 9; n++) begin
            fcyc(1'b1, 1'b0, 8'(n));
            check("f_full", f_full, (n >= 8));
        end
        for (int n = 1; n <= 9; n++) begin
            fcyc(1'b0, 1'b1, 8'h00);
            check("f_rd_data", f_dout, 8'((n > 8) ? 8 : n));
            check("f_empty", f_empty, (n >= 8));
        end

        ed = 8'd8;
        for (int c = 0; c < 60; c++) begin
            logic wr, rd;
            logic [7:0] d;
            wr = 1'($urandom);
            rd = 1'($urandom);
            d  = 8'($urandom);
            if (wr && rd && (q.size() == 0 || q.size() == N))
                rd = 1'b0;
            fcyc(wr, rd, d);
            if (rd && q.size() > 0)
                ed = q.pop_front();
            if (wr && q.size() < N)
                q.push_back(d);
            check("f_rand_dout", f_dout, ed);
            check("f_rand_full", f_full, (q.size() == N));
            check("f_rand_empty", f_empty, (q.size() == 0));
        end

        repeat (3) cyc(1'b0, 1'b1);
        repeat (25) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);

        cyc(1'b0, 1'b1);
        repeat (12) cyc(1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b1);
        repeat (22) cyc(1'b1, 1'b1);

        for (int e = 0; e < 8; e++) begin
            int len;
            len = $urandom_range(30, 0);
            for (int c = 0; c < len; c++)
                cyc(1'b1, 1'($urandom));
            len = $urandom_range(3, 1);
            for (int c = 0; c < len; c++)
                cyc(1'b0, 1'($urandom));
        end
        repeat (20) cyc(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
